// File: rtl/pixie_pkg.sv
// Shared types and constants for the Pixie DMA fetch path: FSM states, 1802 state codes,
// default display base, and page-local pointer arithmetic.
package pixie_pkg;

   localparam logic [15:0] DEFAULT_START_ADDR = 16'h0900;

   localparam logic [1:0] SC_FETCH   = 2'b00;
   localparam logic [1:0] SC_EXECUTE = 2'b01;
   localparam logic [1:0] SC_DMA     = 2'b10;
   localparam logic [1:0] SC_INT     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DELIVER,
      ST_LINE_END
   } dma_state_e;

   // R0 only walks within its 256-byte page; the high byte is never carried into.
   function automatic logic [15:0] page_add(input logic [15:0] a, input logic [7:0] d);
      return {a[15:8], a[7:0] + d};
   endfunction

   function automatic logic [15:0] page_sub(input logic [15:0] a, input logic [7:0] d);
      return {a[15:8], a[7:0] - d};
   endfunction

endpackage

// File: rtl/pixie_dma_fetch_if.sv
// RAM read handshake plus the byte stream handed to the video stage.
interface pixie_dma_fetch_if;

   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic [7:0]  data_out;
   logic        data_valid;

   modport master (
      output mem_addr, mem_req, data_out, data_valid,
      input  mem_ack, mem_data
   );

   modport slave (
      input  mem_addr, mem_req, data_out, data_valid,
      output mem_ack, mem_data
   );

endinterface

// File: rtl/pixie_dma_addr_gen.sv
// R0 display pointer: per-byte page-local increment, frame reload, and (with
// PIXIE_DMA_LINE_REPEAT_EN defined) row rewind so each row is shown on LINE_REPEAT scanlines.
module pixie_dma_addr_gen
   import pixie_pkg::*;
#(
   parameter logic [15:0] START_ADDR     = DEFAULT_START_ADDR,
   parameter int          BYTES_PER_LINE = 8,
   parameter int          LINE_REPEAT    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame,
   input  logic        idle,
   input  logic        advance,
   input  logic        line_end,
   output logic [15:0] r0
);

   logic reload_pending;
   logic reload_now;
   logic rewind;

   // A frame start never disturbs a running burst; it is deferred to the end of the line.
   assign reload_now = (frame && idle) || (line_end && (reload_pending || frame));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r0             <= START_ADDR;
         reload_pending <= 1'b0;
      end else begin
         if (reload_now)
            r0 <= START_ADDR;
         else if (advance)
            r0 <= page_add(r0, 8'd1);
         else if (rewind)
            r0 <= page_sub(r0, STRIDE_OF(BYTES_PER_LINE));

         if (reload_now)
            reload_pending <= 1'b0;
         else if (frame && !idle)
            reload_pending <= 1'b1;
      end
   end

   function automatic logic [7:0] STRIDE_OF(input int n);
      return n[7:0];
   endfunction

`ifdef PIXIE_DMA_LINE_REPEAT_EN
   localparam int LCW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

   logic [LCW-1:0] line_cnt;

   assign rewind = line_end && (line_cnt < LCW'(LINE_REPEAT - 1));

   always_ff @(posedge clk) begin
      if (!reset)
         line_cnt <= '0;
      else if (reload_now)
         line_cnt <= '0;
      else if (line_end)
         line_cnt <= rewind ? line_cnt + 1'b1 : '0;
   end
`else
   logic unused_repeat_cfg;

   assign rewind            = 1'b0;
   assign unused_repeat_cfg = (LINE_REPEAT > 0);
`endif

endmodule

// File: rtl/pixie_dma_fetch.sv
// CDP1802-style DMA-out fetch for the 1861 Pixie: one BYTES_PER_LINE burst per dmao_n fall.
// Optional row repetition is enabled by defining PIXIE_DMA_LINE_REPEAT_EN.
module pixie_dma_fetch
   import pixie_pkg::*;
#(
   parameter logic [15:0] START_ADDR     = DEFAULT_START_ADDR,
   parameter int          BYTES_PER_LINE = 8,
   parameter int          LINE_REPEAT    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic                  dmao_n,
   input  logic                  int_in,
   pixie_dma_fetch_if.master     bus,
   output logic [1:0]            SC,
   output logic                  busy,
   output logic                  overrun
);

   localparam int BCW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

   dma_state_e     state;
   dma_state_e     state_nxt;
   logic           dmao_prev;
   logic [BCW-1:0] byte_cnt;
   logic [7:0]     data_q;
   logic [15:0]    r0;
   logic           dma_fall;
   logic           frame;
   logic           last_byte;
   logic           advance;

   assign dma_fall  = clk_enable && dmao_prev && !dmao_n;
   assign frame     = clk_enable && int_in;
   assign last_byte = (byte_cnt == BCW'(BYTES_PER_LINE - 1));
   assign advance   = (state == ST_REQ) && bus.mem_ack;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:     if (dma_fall) state_nxt = ST_REQ;
         ST_REQ:      if (bus.mem_ack) state_nxt = ST_DELIVER;
         ST_DELIVER:  state_nxt = last_byte ? ST_LINE_END : ST_REQ;
         ST_LINE_END: state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req    = (state == ST_REQ);
      bus.data_valid = (state == ST_DELIVER);
      busy           = (state != ST_IDLE);
      SC             = busy ? SC_DMA : SC_FETCH;
   end

   assign bus.mem_addr = r0;
   assign bus.data_out = data_q;

   // dmao_prev resets low so a request already asserted at reset release is not taken as an edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dmao_prev <= 1'b0;
         byte_cnt  <= '0;
         data_q    <= 8'h00;
         overrun   <= 1'b0;
      end else begin
         if (clk_enable)
            dmao_prev <= dmao_n;
         if (dma_fall && (state != ST_IDLE))
            overrun <= 1'b1;
         if (state == ST_IDLE)
            byte_cnt <= '0;
         else if (state == ST_DELIVER)
            byte_cnt <= byte_cnt + 1'b1;
         if (advance)
            data_q <= bus.mem_data;
      end
   end

   pixie_dma_addr_gen #(
      .START_ADDR     (START_ADDR),
      .BYTES_PER_LINE (BYTES_PER_LINE),
      .LINE_REPEAT    (LINE_REPEAT)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .frame    (frame),
      .idle     (state == ST_IDLE),
      .advance  (advance),
      .line_end (state == ST_LINE_END),
      .r0       (r0)
   );

endmodule

// File: tb/tb_pixie_dma_fetch.sv
// Bench for pixie_dma_fetch: directed steps plus randomized bursts against a
// row-pointer model of the display fetch (row repeat modelled when PIXIE_DMA_LINE_REPEAT_EN is set).
module tb_pixie_dma_fetch;

   localparam int BPL = 8;
   localparam int REP = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clk_enable = 1'b1;
   logic       dmao_n = 1'b1;
   logic       int_in = 1'b0;
   logic [1:0] SC;
   logic       busy;
   logic       overrun;

   pixie_dma_fetch_if bus();

   pixie_dma_fetch #(
      .START_ADDR     (16'h0900),
      .BYTES_PER_LINE (BPL),
      .LINE_REPEAT    (REP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .dmao_n     (dmao_n),
      .int_in     (int_in),
      .bus        (bus),
      .SC         (SC),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial forever #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  ram [256];
   int          wait_cycles = 0;
   logic [7:0]  data_q [$];
   logic [15:0] addr_q [$];

   // Reference model: which row of the page the next scanline shows.
   logic [7:0]  m_ptr = 8'h00;
   int          m_line = 0;
   bit          m_pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RAM responder: acks after wait_cycles, checks the address holds while waiting.
   initial begin
      int          wc;
      logic [15:0] held;
      wc = 0;
      held = 16'h0000;
      bus.mem_ack = 1'b0;
      bus.mem_data = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.mem_req !== 1'b1) begin
            bus.mem_ack = 1'b0;
            wc = 0;
         end else begin
            if (wc == 0) held = bus.mem_addr;
            else check("addr_hold", bus.mem_addr, held);
            if (wc >= wait_cycles) begin
               bus.mem_ack = 1'b1;
               bus.mem_data = ram[bus.mem_addr[7:0]];
               addr_q.push_back(bus.mem_addr);
            end else begin
               bus.mem_ack = 1'b0;
            end
            wc++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) data_q.push_back(bus.data_out);
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic model_line_done();
`ifdef PIXIE_DMA_LINE_REPEAT_EN
      if (m_line < REP - 1) m_line++;
      else begin
         m_line = 0;
         m_ptr = m_ptr + 8'(BPL);
      end
`else
      m_ptr = m_ptr + 8'(BPL);
`endif
      if (m_pend) begin
         m_ptr = 8'h00;
         m_line = 0;
         m_pend = 1'b0;
      end
   endtask

   task automatic check_burst(input string tag);
      logic [7:0] a;
      logic [7:0] d;
      logic [15:0] ad;
      check({tag, "_strobes"}, data_q.size(), BPL);
      check({tag, "_reads"}, addr_q.size(), BPL);
      for (int i = 0; i < BPL; i++) begin
         a = m_ptr + 8'(i);
         d = (i < data_q.size()) ? data_q[i] : 8'hxx;
         ad = (i < addr_q.size()) ? addr_q[i] : 16'hxxxx;
         check({tag, "_data"}, d, ram[a]);
         check({tag, "_addr"}, ad, {8'h09, a});
      end
      model_line_done();
   endtask

   // kind: 0 plain, 1 int_in pulse mid-burst, 2 second dmao_n fall mid-burst
   task automatic run_burst(input string tag, input int wt, input int kind, output int lat);
      int n;
      data_q.delete();
      addr_q.delete();
      wait_cycles = wt;
      @(negedge clk);
      dmao_n = 1'b0;
      @(negedge clk);
      dmao_n = 1'b1;
      n = 1;
      while (busy === 1'b1 && n < 400) begin
         check({tag, "_sc"}, SC, 2'b10);
         @(negedge clk);
         n++;
         int_in = (kind == 1 && n == 6);
         dmao_n = !(kind == 2 && n == 6);
         if (kind == 1 && n == 6) m_pend = 1'b1;
      end
      int_in = 1'b0;
      dmao_n = 1'b1;
      check({tag, "_done"}, busy, 1'b0);
      check({tag, "_sc_idle"}, SC, 2'b00);
      lat = n - 1;
      check_burst(tag);
   endtask

   initial begin
      int lat;
      int k;
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) ram[i] = 8'(i + 1);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_addr", bus.mem_addr, 16'h0900);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_data_out", bus.data_out, 8'h00);
      check("rst_data_valid", bus.data_valid, 1'b0);
      check("rst_sc", SC, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // First burst: 01..08, zero-wait, 17 clocks
      run_burst("first", 0, 0, lat);
      check("first_latency", lat, 2 * BPL + 1);

      // Four more bursts (covers row repeat and the fifth-row advance)
      for (int i = 0; i < 4; i++) run_burst("repeat", int'($urandom_range(0, 2)), 0, lat);

      // Frame interrupt mid-burst: finishes on old pointer, next burst from the base
      run_burst("int_mid", 0, 1, lat);
      run_burst("after_int", 0, 0, lat);

      // Walk the page to 09F8 and across the wrap
      for (int i = 0; i < 33; i++) run_burst("wrap", int'($urandom_range(0, 1)), 0, lat);

      // Request edge while clk_enable low is not seen
      data_q.delete();
      @(negedge clk);
      clk_enable = 1'b0;
      dmao_n = 1'b0;
      repeat (2) @(negedge clk);
      dmao_n = 1'b1;
      @(negedge clk);
      clk_enable = 1'b1;
      repeat (3) @(negedge clk);
      check("gated_busy", busy, 1'b0);
      check("gated_strobes", data_q.size(), 0);

      // Slow RAM plus a second request mid-burst
      check("pre_overrun", overrun, 1'b0);
      run_burst("slow_ovr", 3, 2, lat);
      check("overrun_set", overrun, 1'b1);
      check("slow_latency", lat, BPL * 5 + 1);
      repeat (5) @(negedge clk);
      check("ovr_no_extra", data_q.size(), BPL);

      // Reset during byte 5
      data_q.delete();
      addr_q.delete();
      wait_cycles = 0;
      @(negedge clk);
      dmao_n = 1'b0;
      @(negedge clk);
      dmao_n = 1'b1;
      k = 0;
      while (data_q.size() < 4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid_reached", busy, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_req", bus.mem_req, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_valid", bus.data_valid, 1'b0);
      check("rst_mid_overrun", overrun, 1'b0);
      reset = 1'b1;
      m_ptr = 8'h00;
      m_line = 0;
      m_pend = 1'b0;
      @(negedge clk);
      run_burst("after_rst", 0, 0, lat);

      // Randomized traffic with frame interrupts idle and mid-burst
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            int_in = 1'b1;
            @(negedge clk);
            int_in = 1'b0;
            m_ptr = 8'h00;
            m_line = 0;
         end
         run_burst("rand", int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0) ? 1 : 0, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
